elastic_routing_tree: RTL and testbench
=======================================

ELASTIC_ROUTING_TREE -- requirements
Module: elastic_routing_tree

Interface
REQ-001 SHALL have parameter INPUT_WORD_BIT_WIDTH, default 8, activation word width in bits.
REQ-002 SHALL have parameter NUMBER_OF_ROUTING_TREE_OUTPUTS, default 16, number of output channels N.
- N must be a power of two and at least 2.
REQ-003 SHALL derive localparams ROUTING_CODE_BIT_WIDTH = $clog2(N) and NUMBER_OF_ROUTING_TREE_LEVELS = L = $clog2(N).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port resetn, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port i_valid, input, 1 bit, upstream word valid.
REQ-007 SHALL have port o_ready, output, 1 bit, the tree can accept the upstream word.
REQ-008 SHALL have port i_input, input, INPUT_WORD_BIT_WIDTH bits, the upstream word.
REQ-009 SHALL have port i_routing_code, input, ROUTING_CODE_BIT_WIDTH bits, the destination index; the MSB selects at level 1.
REQ-010 SHALL have port i_broadcast, input, 1 bit, deliver the word to all N outputs.
REQ-011 SHALL have port o_valid, output, N-entry array of 1 bit, per-output word valid.
REQ-012 SHALL have port i_ready, input, N-entry array of 1 bit, per-output downstream ready.
REQ-013 SHALL have port o_outputs, output, N-entry array of INPUT_WORD_BIT_WIDTH bits, per-output data.

Function
REQ-014 SHALL implement L register stages; stage s (1..L) holds 2^s nodes, and each node stores valid, data, residual code and broadcast flag.
- Stage-L nodes drive o_valid/o_outputs[k] directly.
REQ-015 SHALL transfer upstream when i_valid && o_ready, and a node-to-child transfer when the node is valid and its target child(ren) are ready.
REQ-016 SHALL route each non-broadcast word to exactly one child per level, left child when the consumed code bit is 0 and right when it is 1.
- At level s the consumed bit is code bit L-s.
- The residual code is shifted to the next stage.
REQ-017 SHALL compute node ready = !valid || (node drains this cycle); at stage L, drain = i_ready[k].
- This ready chain is combinational across all L levels.
REQ-018 SHALL make a broadcast node target both children and drain only when both are ready in the same cycle.
- A broadcast word reaches all N outputs, each with identical data.
REQ-019 SHALL give, with no backpressure, latency of exactly L cycles from upstream accept to o_valid[dest]=1, and sustain one word per cycle for any code sequence.
REQ-020 SHALL hold data, code and flag stable while a node is valid and not draining; no word is dropped or duplicated.
REQ-021 SHALL preserve order between two words with the same destination.
- Words to different destinations may overtake only via independent branches.
REQ-022 SHALL let a stalled branch block only upstream words whose path includes that branch; the sibling subtree keeps flowing.
REQ-023 SHALL keep o_outputs[k] at 0 whenever o_valid[k]=0.
REQ-024 SHALL drive o_ready=0 while i_valid=0 only if the path for the current i_routing_code is blocked, so o_ready depends only on tree state and on i_routing_code/i_broadcast.

Reset
REQ-025 SHALL, while resetn=0, clear every node's valid, data, code and flag asynchronously.
- Consequently o_valid=all 0 and o_outputs=all 0; o_ready=1 after reset.
REQ-026 SHALL discard all in-flight words on reset assertion mid-operation, and resume accepting on the first rising clk edge after deassertion.

Configuration
REQ-027 SHALL, when macro ROUTING_TREE_BROADCAST_EN is defined, implement the broadcast behaviour of REQ-018.
REQ-028 SHALL, when ROUTING_TREE_BROADCAST_EN is undefined, keep port i_broadcast but ignore it.
- No broadcast flag storage is built.
- Every word is unicast per REQ-016.

Verification
REQ-029 SHALL cover, with N=16 and W=8: after reset, drive i_valid=1, code=5, data=0xA5 with all i_ready=1 -> o_valid[5]=1 and o_outputs[5]=0xA5 exactly 4 cycles after accept, all other outputs 0.
REQ-030 SHALL cover: stream codes 0..15 on consecutive cycles with data=code+0x10 and all ready -> o_ready stays 1, and each output k shows 0x10+k once, cycle k+4.
REQ-031 SHALL cover: i_ready[3]=0, send code 3 twice then code 12 -> code 12 delivered after 4 cycles; code-3 words held stable; on i_ready[3]=1 both drain in order.
REQ-032 SHALL cover, with ROUTING_TREE_BROADCAST_EN: broadcast data=0x7E, i_ready[9]=0 for 3 cycles -> 15 outputs get 0x7E on schedule; output 9 gets it after release; no duplicates.
- Same test without the macro: only output code[3:0] receives the word.
REQ-033 SHALL cover: assert resetn=0 mid-stream with 6 words in flight -> all o_valid drop to 0 without waiting for clk; none of the 6 words appear after release; a new word delivers in 4 cycles.

Source files
------------

// File: rtl/elastic_routing_tree.sv
// Elastic binary routing tree: each upstream word walks L registered levels to one of N outputs.
// Define ROUTING_TREE_BROADCAST_EN to build broadcast delivery to all outputs; otherwise i_broadcast is ignored.
module elastic_routing_tree #(
    parameter int INPUT_WORD_BIT_WIDTH           = 8,
    parameter int NUMBER_OF_ROUTING_TREE_OUTPUTS = 16
) (
    input  logic                                                              clk,
    input  logic                                                              resetn,
    input  logic                                                              i_valid,
    output logic                                                              o_ready,
    input  logic [INPUT_WORD_BIT_WIDTH-1:0]                                   i_input,
    input  logic [$clog2(NUMBER_OF_ROUTING_TREE_OUTPUTS)-1:0]                 i_routing_code,
    input  logic                                                              i_broadcast,
    output logic [NUMBER_OF_ROUTING_TREE_OUTPUTS-1:0]                         o_valid,
    input  logic [NUMBER_OF_ROUTING_TREE_OUTPUTS-1:0]                         i_ready,
    output logic [NUMBER_OF_ROUTING_TREE_OUTPUTS-1:0][INPUT_WORD_BIT_WIDTH-1:0] o_outputs
);
    localparam int W                             = INPUT_WORD_BIT_WIDTH;
    localparam int N                             = NUMBER_OF_ROUTING_TREE_OUTPUTS;
    localparam int ROUTING_CODE_BIT_WIDTH        = $clog2(N);
    localparam int NUMBER_OF_ROUTING_TREE_LEVELS = $clog2(N);
    localparam int L                             = NUMBER_OF_ROUTING_TREE_LEVELS;
    localparam int CW                            = ROUTING_CODE_BIT_WIDTH;

    logic bcast_in;
    logic up_fire;

`ifdef ROUTING_TREE_BROADCAST_EN
    assign bcast_in = i_broadcast;
`else
    logic unused_broadcast;
    assign bcast_in         = 1'b0;
    assign unused_broadcast = i_broadcast;
`endif

    // Stage s holds 2^s nodes; node j feeds children 2j (code bit 0) and 2j+1 (code bit 1).
    // The stored code is pre-shifted so the bit steering into the next stage is always the MSB.
    for (genvar s = 1; s <= L; s++) begin : g_stage
        localparam int NN = 2 ** s;
        localparam int NP = NN / 2;

        logic [NN-1:0]                vld;
        logic [NN-1:0]                rdy;
        logic [NN-1:0]                drn;
        logic [NN-1:0]                ld;
        logic [NN-1:0]                bc;
        logic [NN-1:0][W-1:0]         dat;
        logic [NN-1:0][CW-1:0]        cod;
        logic [NP-1:0]                p_fire;
        logic [NP-1:0]                p_bc;
        logic [NP-1:0][W-1:0]         p_dat;
        logic [NP-1:0][CW-1:0]        p_cod;

        if (s == 1) begin : g_root
            assign p_fire = up_fire;
            assign p_bc   = bcast_in;
            assign p_dat  = i_input;
            assign p_cod  = i_routing_code;
        end else begin : g_inner
            assign p_fire = g_stage[s-1].drn;
            assign p_bc   = g_stage[s-1].bc;
            assign p_dat  = g_stage[s-1].dat;
            assign p_cod  = g_stage[s-1].cod;
        end

        always_comb begin
            ld = '0;
            for (int c = 0; c < NN; c++) begin
                ld[c] = p_fire[c/2] && (p_bc[c/2] || (p_cod[c/2][CW-1] == c[0]));
            end
        end

        // Drain decisions look at the next stage's ready, so the ready chain is combinational root to leaf.
        if (s == L) begin : g_leaf
            logic unused_leaf;
            assign drn         = vld & i_ready;
            assign unused_leaf = ^{cod, bc};
        end else begin : g_branch
            always_comb begin
                drn = '0;
                for (int j = 0; j < NN; j++) begin
                    if (bc[j]) begin
                        drn[j] = vld[j] && g_stage[s+1].rdy[2*j] && g_stage[s+1].rdy[2*j+1];
                    end else begin
                        drn[j] = vld[j] && g_stage[s+1].rdy[2*j + (cod[j][CW-1] ? 1 : 0)];
                    end
                end
            end
        end

        assign rdy = ~vld | drn;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                vld <= '0;
                dat <= '0;
                cod <= '0;
            end else begin
                for (int j = 0; j < NN; j++) begin
                    if (ld[j]) begin
                        vld[j] <= 1'b1;
                        dat[j] <= p_dat[j/2];
                        cod[j] <= p_cod[j/2] << 1;
                    end else if (drn[j]) begin
                        vld[j] <= 1'b0;
                        dat[j] <= '0;
                        cod[j] <= '0;
                    end
                end
            end
        end

`ifdef ROUTING_TREE_BROADCAST_EN
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                bc <= '0;
            end else begin
                for (int j = 0; j < NN; j++) begin
                    if (ld[j]) begin
                        bc[j] <= p_bc[j/2];
                    end else if (drn[j]) begin
                        bc[j] <= 1'b0;
                    end
                end
            end
        end
`else
        assign bc = '0;
`endif
    end

    // o_ready never looks at i_valid, only at the path the current code or broadcast would take.
    always_comb begin
        if (bcast_in) begin
            o_ready = g_stage[1].rdy[0] && g_stage[1].rdy[1];
        end else begin
            o_ready = g_stage[1].rdy[i_routing_code[CW-1]];
        end
    end

    assign up_fire   = i_valid && o_ready;
    assign o_valid   = g_stage[L].vld;
    assign o_outputs = g_stage[L].dat;

endmodule

// File: tb/tb_elastic_routing_tree.sv
// Directed testbench for elastic_routing_tree with N=16, W=8; expected values are hand-computed.
module tb_elastic_routing_tree;
    localparam int W = 8;
    localparam int N = 16;

    logic                clk = 1'b0;
    logic                resetn = 1'b1;
    logic                i_valid = 1'b0;
    logic                o_ready;
    logic [W-1:0]        i_input = '0;
    logic [3:0]          i_routing_code = '0;
    logic                i_broadcast = 1'b0;
    logic [N-1:0]        o_valid;
    logic [N-1:0]        i_ready = '1;
    logic [N-1:0][W-1:0] o_outputs;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    elastic_routing_tree #(
        .INPUT_WORD_BIT_WIDTH(W),
        .NUMBER_OF_ROUTING_TREE_OUTPUTS(N)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_input(i_input),
        .i_routing_code(i_routing_code),
        .i_broadcast(i_broadcast),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_outputs(o_outputs)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_valid        = 1'b0;
        i_input        = '0;
        i_routing_code = '0;
        i_broadcast    = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] codes [3];
        codes = '{4'd0, 4'd7, 4'd15};
        idle_inputs();
        i_ready = '1;
        #2 resetn = 1'b0;
        #1;
        repeat (2) tick();
        n_cmp++;
        if (o_valid !== '0) begin
            n_bad++; $display("FAIL reset_valid: got %h expected %h", o_valid, 16'h0);
        end
        n_cmp++;
        if (o_outputs !== '0) begin
            n_bad++; $display("FAIL reset_outputs: got %h expected 0", o_outputs);
        end
        for (int i = 0; i < 3; i++) begin
            i_routing_code = codes[i];
            #1;
            n_cmp++;
            if (o_ready !== 1'b1) begin
                n_bad++; $display("FAIL reset_ready code %0d: got %b expected 1", codes[i], o_ready);
            end
        end
        idle_inputs();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [N-1:0][W-1:0] exp_out;
        i_ready        = '1;
        i_valid        = 1'b1;
        i_routing_code = 4'd5;
        i_input        = 8'hA5;
        #1;
        n_cmp++;
        if (o_ready !== 1'b1) begin
            n_bad++; $display("FAIL single_ready: got %b expected 1", o_ready);
        end
        tick();
        idle_inputs();
        tick();
        tick();
        n_cmp++;
        if (o_valid !== '0) begin
            n_bad++; $display("FAIL single_early: got %h expected %h", o_valid, 16'h0);
        end
        tick();
        exp_out    = '0;
        exp_out[5] = 8'hA5;
        n_cmp++;
        if (o_valid !== 16'h0020) begin
            n_bad++; $display("FAIL single_valid: got %h expected %h", o_valid, 16'h0020);
        end
        n_cmp++;
        if (o_outputs !== exp_out) begin
            n_bad++; $display("FAIL single_data: got %h expected %h", o_outputs, exp_out);
        end
        tick();
        n_cmp++;
        if (o_valid !== '0 || o_outputs !== '0) begin
            n_bad++; $display("FAIL single_gone: got %h expected %h", o_valid, 16'h0);
        end
    endtask

    task automatic test_stream();
        int                  seen [N];
        int                  k;
        logic [N-1:0]        exp_v;
        logic [N-1:0][W-1:0] exp_out;
        for (int i = 0; i < N; i++) seen[i] = 0;
        i_ready = '1;
        for (int t = 0; t < 22; t++) begin
            if (t < 16) begin
                i_valid        = 1'b1;
                i_routing_code = 4'(t);
                i_input        = 8'h10 + 8'(t);
                #1;
                n_cmp++;
                if (o_ready !== 1'b1) begin
                    n_bad++; $display("FAIL stream_ready t=%0d: got %b expected 1", t, o_ready);
                end
            end else begin
                idle_inputs();
            end
            tick();
            k       = t - 3;
            exp_v   = '0;
            exp_out = '0;
            if (k >= 0 && k < N) begin
                exp_v[k]   = 1'b1;
                exp_out[k] = 8'h10 + 8'(k);
            end
            n_cmp++;
            if (o_valid !== exp_v || o_outputs !== exp_out) begin
                n_bad++;
                $display("FAIL stream_out tick=%0d: got %h/%h expected %h/%h", t + 1, o_valid, o_outputs, exp_v, exp_out);
            end
            for (int i = 0; i < N; i++) if (o_valid[i] === 1'b1) seen[i]++;
        end
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (seen[i] != 1) begin
                n_bad++; $display("FAIL stream_count out %0d: got %0d expected 1", i, seen[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [3:0]          sc [3];
        logic [W-1:0]        sd [3];
        logic [N-1:0]        ev [4];
        logic [W-1:0]        drain_seq [4];
        logic [3:0]          probe_code [3];
        logic                probe_rdy [3];
        logic [N-1:0][W-1:0] exp_out;
        logic [N-1:0]        exp_v;
        sc         = '{4'd3, 4'd3, 4'd12};
        sd         = '{8'h31, 8'h32, 8'hC1};
        ev         = '{16'h0008, 16'h0008, 16'h1008, 16'h0008};
        drain_seq  = '{8'h32, 8'h33, 8'h34, 8'h00};
        probe_code = '{4'd3, 4'd4, 4'd12};
        probe_rdy  = '{1'b0, 1'b0, 1'b1};
        i_ready    = 16'hFFF7;
        for (int t = 0; t < 3; t++) begin
            i_valid        = 1'b1;
            i_routing_code = sc[t];
            i_input        = sd[t];
            #1;
            n_cmp++;
            if (o_ready !== 1'b1) begin
                n_bad++; $display("FAIL stall_accept t=%0d: got %b expected 1", t, o_ready);
            end
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_out    = '0;
            exp_out[3] = 8'h31;
            if (ev[i][12]) exp_out[12] = 8'hC1;
            n_cmp++;
            if (o_valid !== ev[i] || o_outputs !== exp_out) begin
                n_bad++;
                $display("FAIL stall_hold tick=%0d: got %h/%h expected %h/%h", i + 4, o_valid, o_outputs, ev[i], exp_out);
            end
        end
        for (int t = 0; t < 2; t++) begin
            i_valid        = 1'b1;
            i_routing_code = 4'd3;
            i_input        = 8'h33 + 8'(t);
            #1;
            n_cmp++;
            if (o_ready !== 1'b1) begin
                n_bad++; $display("FAIL stall_fill t=%0d: got %b expected 1", t, o_ready);
            end
            tick();
        end
        idle_inputs();
        exp_out    = '0;
        exp_out[3] = 8'h31;
        n_cmp++;
        if (o_valid !== 16'h0008 || o_outputs !== exp_out) begin
            n_bad++; $display("FAIL stall_full: got %h/%h expected %h/%h", o_valid, o_outputs, 16'h0008, exp_out);
        end
        for (int i = 0; i < 3; i++) begin
            i_routing_code = probe_code[i];
            #1;
            n_cmp++;
            if (o_ready !== probe_rdy[i]) begin
                n_bad++; $display("FAIL stall_ready code %0d: got %b expected %b", probe_code[i], o_ready, probe_rdy[i]);
            end
        end
        idle_inputs();
        i_ready = '1;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_out    = '0;
            exp_out[3] = drain_seq[i];
            exp_v      = (drain_seq[i] != 8'h00) ? 16'h0008 : 16'h0000;
            n_cmp++;
            if (o_valid !== exp_v || o_outputs !== exp_out) begin
                n_bad++;
                $display("FAIL stall_drain step=%0d: got %h/%h expected %h/%h", i, o_valid, o_outputs, exp_v, exp_out);
            end
        end
    endtask

    task automatic test_broadcast();
        logic [N-1:0]        exp_v;
        logic [N-1:0][W-1:0] exp_out;
        i_ready        = 16'hFDFF;
        i_valid        = 1'b1;
        i_broadcast    = 1'b1;
        i_routing_code = 4'd6;
        i_input        = 8'h7E;
        #1;
        n_cmp++;
        if (o_ready !== 1'b1) begin
            n_bad++; $display("FAIL bcast_ready: got %b expected 1", o_ready);
        end
        tick();
        idle_inputs();
        tick();
        tick();
        n_cmp++;
        if (o_valid !== '0) begin
            n_bad++; $display("FAIL bcast_early: got %h expected %h", o_valid, 16'h0);
        end
        tick();
        exp_out = '0;
`ifdef ROUTING_TREE_BROADCAST_EN
        exp_v = 16'hFFFF;
        for (int i = 0; i < N; i++) exp_out[i] = 8'h7E;
`else
        exp_v      = 16'h0040;
        exp_out[6] = 8'h7E;
`endif
        n_cmp++;
        if (o_valid !== exp_v || o_outputs !== exp_out) begin
            n_bad++; $display("FAIL bcast_arrive: got %h/%h expected %h/%h", o_valid, o_outputs, exp_v, exp_out);
        end
        exp_out = '0;
`ifdef ROUTING_TREE_BROADCAST_EN
        exp_v      = 16'h0200;
        exp_out[9] = 8'h7E;
`else
        exp_v = 16'h0000;
`endif
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (o_valid !== exp_v || o_outputs !== exp_out) begin
                n_bad++; $display("FAIL bcast_hold step=%0d: got %h/%h expected %h/%h", i, o_valid, o_outputs, exp_v, exp_out);
            end
        end
        i_ready = '1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (o_valid !== '0 || o_outputs !== '0) begin
                n_bad++; $display("FAIL bcast_after step=%0d: got %h expected %h", i, o_valid, 16'h0);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [N-1:0][W-1:0] exp_out;
        i_ready = '0;
        for (int t = 0; t < 6; t++) begin
            i_valid        = 1'b1;
            i_routing_code = 4'(t);
            i_input        = 8'h50 + 8'(t);
            tick();
        end
        idle_inputs();
        exp_out    = '0;
        exp_out[0] = 8'h50;
        exp_out[1] = 8'h51;
        exp_out[2] = 8'h52;
        n_cmp++;
        if (o_valid !== 16'h0007 || o_outputs !== exp_out) begin
            n_bad++; $display("FAIL mid_inflight: got %h/%h expected %h/%h", o_valid, o_outputs, 16'h0007, exp_out);
        end
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if (o_valid !== '0 || o_outputs !== '0) begin
            n_bad++; $display("FAIL mid_async_clear: got %h/%h expected 0", o_valid, o_outputs);
        end
        n_cmp++;
        if (o_ready !== 1'b1) begin
            n_bad++; $display("FAIL mid_ready: got %b expected 1", o_ready);
        end
        tick();
        tick();
        i_ready = '1;
        resetn  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (o_valid !== '0) begin
                n_bad++; $display("FAIL mid_ghost step=%0d: got %h expected %h", i, o_valid, 16'h0);
            end
        end
        i_valid        = 1'b1;
        i_routing_code = 4'd10;
        i_input        = 8'hBB;
        tick();
        idle_inputs();
        tick();
        tick();
        n_cmp++;
        if (o_valid !== '0) begin
            n_bad++; $display("FAIL mid_new_early: got %h expected %h", o_valid, 16'h0);
        end
        tick();
        exp_out     = '0;
        exp_out[10] = 8'hBB;
        n_cmp++;
        if (o_valid !== 16'h0400 || o_outputs !== exp_out) begin
            n_bad++; $display("FAIL mid_new_word: got %h/%h expected %h/%h", o_valid, o_outputs, 16'h0400, exp_out);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_stall();
        test_broadcast();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
